// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, one-outstanding fetch to instruction memory, 2-entry prefetch FIFO, IF->ID give/get, EX redirect flush.
module instruction_fetch #(
    parameter int                 BITSIZE      = 32,
    parameter logic [BITSIZE-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               resetn_i,
    output logic               IF_MEM_req_o,
    output logic [BITSIZE-1:0] IF_MEM_addr_o,
    input  logic               MEM_IF_ack_i,
    input  logic [31:0]        MEM_IF_data_i,
    output logic               IF_ID_give_o,
    input  logic               ID_IF_get_i,
    output logic [31:0]        IF_ID_instr_o,
    output logic [BITSIZE-1:0] IF_ID_pc_o,
    input  logic               EX_IF_branch_i,
    input  logic [BITSIZE-1:0] EX_IF_target_i
);
    typedef enum logic {FETCH, FLUSH} state_t;
    state_t state, state_nx;
    logic [BITSIZE-1:0] pc, tgt, tgt_al, load_val;
    logic [BITSIZE-1:0] fpc [2];
    logic [31:0] finstr [2];
    logic [1:0] cnt, cnt_mid, cnt_nx;
    logic ack_v, push, pop, redirect;
    assign tgt_al = EX_IF_target_i & ~BITSIZE'(3);
    assign IF_MEM_addr_o = pc;
    assign IF_ID_pc_o = cnt != 0 ? fpc[0] : '0;
    assign IF_ID_instr_o = cnt != 0 ? finstr[0] : '0;
    always_ff @(posedge clk)
        state <= !resetn_i ? FETCH : state_nx;
    // a branch that cannot complete now waits in FLUSH for the pending ack
    always_comb begin
        state_nx = state == FETCH
            ? ((EX_IF_branch_i && IF_MEM_req_o && !MEM_IF_ack_i) ? FLUSH : FETCH)
            : (ack_v ? FETCH : FLUSH);
    end
    always_comb begin
        ack_v        = IF_MEM_req_o && MEM_IF_ack_i;
        IF_ID_give_o = cnt != 0 && !EX_IF_branch_i;
        pop          = IF_ID_give_o && ID_IF_get_i;
        push         = ack_v && state == FETCH && !EX_IF_branch_i;
        redirect     = state == FETCH ? EX_IF_branch_i && (!IF_MEM_req_o || ack_v) : ack_v;
        load_val     = (state == FETCH || EX_IF_branch_i) ? tgt_al : tgt;
        cnt_mid      = cnt - 2'(pop);
        cnt_nx       = EX_IF_branch_i ? 2'd0 : cnt_mid + 2'(push);
    end
    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            pc           <= RESET_VECTOR;
            cnt          <= '0;
            IF_MEM_req_o <= 1'b0;
        end else begin
            pc           <= redirect ? load_val : push ? pc + BITSIZE'(4) : pc;
            cnt          <= cnt_nx;
            IF_MEM_req_o <= cnt_nx != 2'd2;
        end
    end
    // shift-register FIFO: entry 0 is always the head
    always_ff @(posedge clk) begin
        tgt       <= EX_IF_branch_i ? tgt_al : tgt;
        fpc[0]    <= (push && cnt_mid == 2'd0) ? pc : pop ? fpc[1] : fpc[0];
        finstr[0] <= (push && cnt_mid == 2'd0) ? MEM_IF_data_i : pop ? finstr[1] : finstr[0];
        fpc[1]    <= (push && cnt_mid == 2'd1) ? pc : fpc[1];
        finstr[1] <= (push && cnt_mid == 2'd1) ? MEM_IF_data_i : finstr[1];
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: memory model returning data = address, scoreboard of expected deliveries, table and directed redirect cases.
module tb_instruction_fetch;
    logic        clk = 0;
    logic        resetn = 0;
    logic        req, ack, give, get = 0, branch = 0;
    logic [31:0] addr, data, instr, pc, target = 0;
    int          lat = 0, wcnt = 0, nacks = 0;
    int          n_checks = 0, n_pass = 0;
    logic [31:0] sb [$];

    instruction_fetch #(.BITSIZE(32), .RESET_VECTOR(32'h0)) dut (
        .clk(clk), .resetn_i(resetn), .IF_MEM_req_o(req), .IF_MEM_addr_o(addr),
        .MEM_IF_ack_i(ack), .MEM_IF_data_i(data), .IF_ID_give_o(give), .ID_IF_get_i(get),
        .IF_ID_instr_o(instr), .IF_ID_pc_o(pc), .EX_IF_branch_i(branch), .EX_IF_target_i(target)
    );

    always #5 clk = ~clk;

    assign ack  = req && wcnt == lat;
    assign data = addr;

    always @(posedge clk) begin
        wcnt  <= (!resetn || !req || ack) ? 0 : wcnt + 1;
        nacks <= !resetn ? 0 : (req && ack) ? nacks + 1 : nacks;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // every transfer must match the head of the scoreboard
    always @(negedge clk) begin
        if (resetn && give && get) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected: got pc %h expected no transfer at %0t", pc, $time);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("deliver_pc", pc, e);
                check("deliver_instr", instr, e);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic g, input int l);
        resetn = 0;
        get    = g;
        branch = 0;
        target = 0;
        lat    = l;
        sb.delete();
        tick;
        tick;
        resetn = 1;
    endtask

    task automatic push_seq(input logic [31:0] first, input int n);
        for (int k = 0; k < n; k++) sb.push_back(first + 32'(4 * k));
    endtask

    task automatic drain(input int bound);
        for (int n = 0; n < bound && sb.size() != 0; n++) begin
            mid;
            if (sb.size() != 0) tick;
        end
        tick;
        get = 0;
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // branch t1 in wait cycle c1 and t2 in wait cycle c2 of a 3-wait request to RESET_VECTOR
    task automatic flush2(input logic [31:0] t1, input int c1, input logic [31:0] t2, input int c2,
                          input logic [31:0] exp);
        do_reset(0, 3);
        tick;
        for (int w = 0; w < 4; w++) begin
            branch = (w == c1) || (w == c2);
            target = (w == c2) ? t2 : t1;
            mid;
            check("held_req", {31'd0, req}, 32'd1);
            check("held_addr", addr, 32'h0);
            tick;
            branch = 0;
        end
        mid;
        check("redir_req", {31'd0, req}, 32'd1);
        check("redir_addr", addr, exp);
        check("redir_give", {31'd0, give}, 32'd0);
        tick;
        get = 1;
        push_seq(exp, 2);
        drain(40);
    endtask

    typedef struct {
        int          lat;
        logic [31:0] target;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 32'h0000_0100, 32'h0000_0100};
        vecs[1] = '{2, 32'h0000_0204, 32'h0000_0204};
        vecs[2] = '{0, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        vecs[3] = '{1, 32'h0000_032B, 32'h0000_0328};
        vecs[4] = '{3, 32'h0000_1000, 32'h0000_1000};

        // zero-wait streaming from reset
        do_reset(1, 0);
        push_seq(32'h0, 8);
        mid;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_give", {31'd0, give}, 32'd0);
        check("rst_addr", addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        tick;
        mid;
        check("first_req", {31'd0, req}, 32'd1);
        check("first_addr", addr, 32'h0);
        check("first_give", {31'd0, give}, 32'd0);
        tick;
        mid;
        check("stream_give", {31'd0, give}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick;
            mid;
            check("stream_give", {31'd0, give}, 32'd1);
            check("stream_req", {31'd0, req}, 32'd1);
        end
        tick;
        get = 0;
        check("stream_done", 32'(sb.size()), 32'd0);

        // decode stall fills the FIFO
        do_reset(0, 0);
        tick;
        mid;
        check("empty_pc", pc, 32'h0);
        check("empty_instr", instr, 32'h0);
        tick;
        mid;
        check("stall_give", {31'd0, give}, 32'd1);
        check("stall_req1", {31'd0, req}, 32'd1);
        tick;
        mid;
        check("stall_req_drop", {31'd0, req}, 32'd0);
        repeat (10) tick;
        mid;
        check("stall_req_low", {31'd0, req}, 32'd0);
        check("stall_acks", 32'(nacks), 32'd2);
        check("stall_head", pc, 32'h0);
        tick;
        get = 1;
        push_seq(32'h0, 3);
        drain(20);

        // table: branch with full FIFO and get high, varied latency
        foreach (vecs[i]) begin
            do_reset(0, vecs[i].lat);
            repeat (12) tick;
            mid;
            check("tbl_full_req", {31'd0, req}, 32'd0);
            check("tbl_full_give", {31'd0, give}, 32'd1);
            tick;
            branch = 1;
            target = vecs[i].target;
            get    = 1;
            mid;
            check("tbl_mask", {31'd0, give}, 32'd0);
            tick;
            branch = 0;
            mid;
            check("tbl_flushed", {31'd0, give}, 32'd0);
            check("tbl_req", {31'd0, req}, 32'd1);
            check("tbl_addr", addr, vecs[i].exp);
            push_seq(vecs[i].exp, 4);
            drain(60);
        end

        // redirects against an outstanding request
        flush2(32'h100, 1, 32'h100, 1, 32'h100);
        flush2(32'h200, 0, 32'h300, 1, 32'h300);
        flush2(32'h200, 1, 32'h400, 3, 32'h400);
        flush2(32'h500, 3, 32'h500, 3, 32'h500);

        // reset with a request outstanding and the FIFO occupied
        do_reset(0, 3);
        repeat (5) tick;
        resetn = 0;
        mid;
        check("pre_rst_give", {31'd0, give}, 32'd1);
        check("pre_rst_req", {31'd0, req}, 32'd1);
        tick;
        resetn = 1;
        mid;
        check("mid_rst_req", {31'd0, req}, 32'd0);
        check("mid_rst_give", {31'd0, give}, 32'd0);
        check("mid_rst_addr", addr, 32'h0);
        tick;
        get = 1;
        push_seq(32'h0, 2);
        drain(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
